// File: rtl/regfile_mp.sv
// Multi-port integer register file for the pipelined core: write-first bypass,
// optional hardwired zero register, optional registered read, busy scoreboard.
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit RD_REG   = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NRD*$clog2(NREGS)-1:0]      rd_addr,
  output logic [NRD*XLEN-1:0]               rd_data,
  output logic [NRD-1:0]                    rd_busy,
  input  logic [NWR-1:0]                    we,
  input  logic [NWR*$clog2(NREGS)-1:0]      wr_addr,
  input  logic [NWR*XLEN-1:0]               wr_data,
  input  logic                              bs_en,
  input  logic [$clog2(NREGS)-1:0]          bs_addr,
  output logic [NREGS-1:0]                  busy
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  mem  [NREGS];
  logic [XLEN-1:0]  wdat [NREGS];
  logic [NREGS-1:0] wen;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] busy_q;

  logic [NRD*XLEN-1:0] rd_data_c;
  logic [NRD-1:0]      rd_busy_c;

  // Per-register write decode. Later write ports overwrite earlier ones, so the
  // highest-index port wins on an address collision. Nothing is accepted while
  // reset is held, which also keeps the bypass path quiet during reset.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wen[r]     = 1'b0;
      wdat[r]    = '0;
      set_vec[r] = !reset && bs_en && (bs_addr == AW'(r));
      for (int w = 0; w < NWR; w++) begin
        if (!reset && we[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
          wen[r]  = 1'b1;
          wdat[r] = wr_data[w*XLEN +: XLEN];
        end
      end
    end
    if (ZERO_REG) begin
      wen[0]     = 1'b0;
      set_vec[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wen[r]) begin
          mem[r] <= wdat[r];
        end
      end
    end
  end

  // A freshly issued producer outranks the retiring one, so set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~wen) | set_vec;
    end
  end

  assign busy = busy_q;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          is_zero;
      logic          fwd;

      assign addr    = rd_addr[gi*AW +: AW];
      assign is_zero = ZERO_REG && (addr == AW'(0));
      assign fwd     = BYPASS && wen[addr];

      assign rd_data_c[gi*XLEN +: XLEN] = is_zero ? '0 :
                                          fwd     ? wdat[addr] : mem[addr];
      assign rd_busy_c[gi] = is_zero ? 1'b0 :
                             fwd     ? set_vec[addr] : busy_q[addr];
    end

    if (RD_REG) begin : g_rd_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_data <= '0;
          rd_busy <= '0;
        end else begin
          rd_data <= rd_data_c;
          rd_busy <= rd_busy_c;
        end
      end
    end else begin : g_rd_comb
      assign rd_data = rd_data_c;
      assign rd_busy = rd_busy_c;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations share one stimulus stream and are
// checked every cycle against an array model, plus directed literal checks.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                bs_en;
  logic [AW-1:0]       bs_addr;

  logic [NRD*XLEN-1:0] a_rd_data, b_rd_data, c_rd_data;
  logic [NRD-1:0]      a_rd_busy, b_rd_busy, c_rd_busy;
  logic [NREGS-1:0]    a_busy, b_busy, c_busy;

  // a: bypass, combinational read; b: no bypass; c: bypass, registered read
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(1'b1), .BYPASS(1'b1), .RD_REG(1'b0)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .bs_en(bs_en), .bs_addr(bs_addr), .busy(a_busy));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(1'b1), .BYPASS(1'b0), .RD_REG(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .bs_en(bs_en), .bs_addr(bs_addr), .busy(b_busy));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(1'b1), .BYPASS(1'b1), .RD_REG(1'b1)) dut_c (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(c_rd_data),
    .rd_busy(c_rd_busy), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .bs_en(bs_en), .bs_addr(bs_addr), .busy(c_busy));

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [63:0] m_regs [NREGS];
  bit        m_busy [NREGS];
  bit [63:0] m_c_data [NRD];
  bit        m_c_busy [NRD];

  function automatic void expect_read(input int a, input bit bypass,
                                      output bit [63:0] d, output bit b);
    d = m_regs[a];
    b = m_busy[a];
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end else if (bypass) begin
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && int'(wr_addr[w*AW +: AW]) == a) begin
          d = wr_data[w*XLEN +: XLEN];
          b = bs_en && int'(bs_addr) == a;
        end
      end
    end
  endfunction

  function automatic logic [63:0] model_busy_vec();
    logic [63:0] v = '0;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    return v;
  endfunction

  initial begin : compare
    bit [63:0] da, db, n_regs [NREGS];
    bit        ba, bb, n_busy [NREGS];
    bit [63:0] nc_data [NRD];
    bit        nc_busy [NRD];
    int        a;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_a_rd_data", a_rd_data[63:0] | a_rd_data[127:64], 64'd0);
        check("rst_c_rd_data", c_rd_data[63:0] | c_rd_data[127:64], 64'd0);
        check("rst_c_rd_busy", 64'(c_rd_busy), 64'd0);
        check("rst_busy", 64'(a_busy | b_busy | c_busy), 64'd0);
      end else begin
        for (int p = 0; p < NRD; p++) begin
          a = int'(rd_addr[p*AW +: AW]);
          expect_read(a, 1'b1, da, ba);
          expect_read(a, 1'b0, db, bb);
          check("a_rd_data", a_rd_data[p*XLEN +: XLEN], da);
          check("a_rd_busy", 64'(a_rd_busy[p]), 64'(ba));
          check("b_rd_data", b_rd_data[p*XLEN +: XLEN], db);
          check("b_rd_busy", 64'(b_rd_busy[p]), 64'(bb));
          check("c_rd_data", c_rd_data[p*XLEN +: XLEN], m_c_data[p]);
          check("c_rd_busy", 64'(c_rd_busy[p]), 64'(m_c_busy[p]));
          nc_data[p] = da;
          nc_busy[p] = ba;
        end
        check("a_busy", 64'(a_busy), model_busy_vec());
        check("b_busy", 64'(b_busy), model_busy_vec());
        check("c_busy", 64'(c_busy), model_busy_vec());
      end
      n_regs = m_regs;
      n_busy = m_busy;
      for (int w = 0; w < NWR; w++) begin
        if (we[w]) begin
          a = int'(wr_addr[w*AW +: AW]);
          if (a != 0) n_regs[a] = wr_data[w*XLEN +: XLEN];
          n_busy[a] = 1'b0;
        end
      end
      if (bs_en && bs_addr != 0) n_busy[bs_addr] = 1'b1;
      @(posedge clk);
      if (reset) begin
        for (int r = 0; r < NREGS; r++) begin
          m_regs[r] = '0;
          m_busy[r] = 1'b0;
        end
        for (int p = 0; p < NRD; p++) begin
          m_c_data[p] = '0;
          m_c_busy[p] = 1'b0;
        end
      end else begin
        m_regs = n_regs;
        m_busy = n_busy;
        m_c_data = nc_data;
        m_c_busy = nc_busy;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we    = '0;
    bs_en = 1'b0;
  endtask

  initial begin : stim
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    bs_addr = '0;
    idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    $display("txn: read all registers after reset");
    for (int i = 0; i < NREGS / 2; i++) begin
      rd_addr = {5'(2 * i + 1), 5'(2 * i)};
      settle();
      check("reset_read_p0", a_rd_data[63:0], 64'd0);
      check("reset_read_p1", a_rd_data[127:64], 64'd0);
      check("reset_busy", 64'(a_busy), 64'd0);
      advance();
    end

    $display("txn: write r5 via port 0 with same-cycle read");
    we = 2'b01; wr_addr[4:0] = 5'd5; wr_data[63:0] = 64'hDEAD_BEEF_0000_0001;
    rd_addr = {5'd1, 5'd5};
    settle();
    check("bypass_r5", a_rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    check("nobypass_r5_old", b_rd_data[63:0], 64'd0);
    advance(); idle();
    settle();
    check("nobypass_r5_new", b_rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    check("regread_r5", c_rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    advance();

    $display("txn: both ports write r7");
    we = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {64'h22, 64'h11};
    rd_addr = {5'd5, 5'd7};
    settle();
    check("collide_bypass_r7", a_rd_data[63:0], 64'h22);
    advance(); idle();
    settle();
    check("collide_stored_r7", b_rd_data[63:0], 64'h22);
    advance();

    $display("txn: write and busy-set on r0");
    we = 2'b01; wr_addr[4:0] = 5'd0; wr_data[63:0] = 64'hFF; rd_addr = {5'd0, 5'd0};
    settle();
    check("zero_bypass", a_rd_data[63:0], 64'd0);
    advance(); idle(); bs_en = 1'b1; bs_addr = 5'd0;
    settle();
    check("zero_stored", b_rd_data[63:0], 64'd0);
    advance(); idle();
    settle();
    check("zero_busy", 64'(a_busy[0]), 64'd0);
    advance();

    $display("txn: busy scoreboard on r9");
    rd_addr = {5'd9, 5'd0}; bs_en = 1'b1; bs_addr = 5'd9;
    advance(); idle();
    settle();
    check("busy9_set", 64'(a_busy[9]), 64'd1);
    check("rd_busy9_set", 64'(a_rd_busy[1]), 64'd1);
    advance();
    we = 2'b10; wr_addr[9:5] = 5'd9; wr_data[127:64] = 64'h99; bs_en = 1'b1; bs_addr = 5'd9;
    settle();
    check("rd_busy9_set_wins", 64'(a_rd_busy[1]), 64'd1);
    advance(); idle();
    settle();
    check("busy9_set_wins", 64'(a_busy[9]), 64'd1);
    advance();
    we = 2'b10; wr_addr[9:5] = 5'd9; wr_data[127:64] = 64'hAA;
    settle();
    check("rd_busy9_bypass_clear", 64'(a_rd_busy[1]), 64'd0);
    check("rd_busy9_stored", 64'(b_rd_busy[1]), 64'd1);
    advance(); idle();
    settle();
    check("busy9_cleared", 64'(a_busy[9]), 64'd0);
    advance();

    $display("txn: registered read of r3 then async reset");
    we = 2'b01; wr_addr[4:0] = 5'd3; wr_data[63:0] = 64'h42; rd_addr = {5'd9, 5'd3};
    bs_en = 1'b1; bs_addr = 5'd12;
    advance(); idle();
    settle();
    check("regread_r3", c_rd_data[63:0], 64'h42);
    check("busy12_set", 64'(a_busy[12]), 64'd1);
    reset = 1'b1;
    #1;
    check("async_rst_c_rd_data", c_rd_data[63:0], 64'd0);
    check("async_rst_r3", a_rd_data[63:0], 64'd0);
    check("async_rst_busy", 64'(a_busy), 64'd0);
    we = 2'b01; wr_addr[4:0] = 5'd4; wr_data[63:0] = 64'h99; rd_addr = {5'd9, 5'd4};
    advance();
    reset = 1'b0;
    wr_data[63:0] = 64'h77;
    settle();
    check("write_in_reset_ignored", b_rd_data[63:0], 64'd0);
    advance(); idle();
    settle();
    check("first_write_after_reset", b_rd_data[63:0], 64'h77);
    advance();

    $display("txn: random traffic");
    for (int i = 0; i < 300; i++) begin
      we      = 2'($urandom_range(0, 3));
      wr_addr = 10'($urandom);
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      bs_en   = 1'($urandom_range(0, 1));
      bs_addr = 5'($urandom);
      rd_addr = (i % 4 == 0) ? {wr_addr[9:5], wr_addr[4:0]} : 10'($urandom);
      advance();
    end
    idle();
    repeat (3) advance();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with write-first bypass, an optional hardwired zero register, an optional registered-read mode, and a per-register busy scoreboard. It is the next-generation register file for the pipelined core. It sits between decode (read ports, busy checks) and writeback (write ports, busy clears). Issue logic sets busy bits when it dispatches a long-latency producer such as a load.

## Interface
- XLEN, 64, data width per register
- NREGS, 32, number of registers (power of two, ≥2); AW = $clog2(NREGS) derived locally
- NRD, 2, number of read ports (1..4)
- NWR, 2, number of write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = a read of a register being written this cycle returns the new data
- RD_REG, 0, 0 = combinational read; 1 = registered read, 1-cycle latency

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- rd_addr  in  NRD*AW  read addresses, port p at [p*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
- rd_busy  out  NRD  busy bit of the register addressed by each read port
- we  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- bs_en  in  1  busy-set enable
- bs_addr  in  AW  register to mark busy
- busy  out  NREGS  full scoreboard vector

## Operation
- Storage is NREGS x XLEN flops. Reset clears **all** NREGS entries to 0, including the last one, and clears all busy bits.
- Writes commit on the rising clk edge when we[w]=1.
- Two write ports hitting the same address: the higher port index wins. The lower port's data is discarded.
- ZERO_REG=1:
  - writes to address 0 are dropped;
  - reads of address 0 return 0 regardless of bypass;
  - busy[0] is constant 0, and bs_en on address 0 is ignored.
- Bypass (BYPASS=1): when rd_addr[p] matches an active write in the same cycle, rd_data[p] = that wr_data (highest matching port). Otherwise rd_data[p] is the stored value. With BYPASS=0, reads return the stored value, i.e. the old value.
- Busy scoreboard, updated on the clock edge:
  - bs_en sets busy[bs_addr];
  - any active write clears busy[wr_addr].
  - Same register set and cleared in one cycle: **set wins**, because a new producer is issued.
- rd_busy[p] = busy[rd_addr[p]] after the same-cycle clear is applied. If BYPASS=1 and a write to that address is active this cycle, rd_busy[p]=0 unless bs_en targets it in the same cycle. With BYPASS=0, rd_busy[p] is the stored bit.
- RD_REG=1:
  - rd_data and rd_busy are registered: the value computed per the rules above is sampled at the edge and presented next cycle.
  - Output registers reset to 0.
  - rd_addr is sampled every cycle; there is no enable.
- X on wr_addr or rd_addr with the associated enable low must not corrupt state.

## Timing
- RD_REG=0: rd_data and rd_busy are combinational from rd_addr, we, wr_addr and wr_data (bypass path); 0-cycle latency.
- RD_REG=1: 1-cycle latency from rd_addr to rd_data and rd_busy.
- Write visible through storage: the cycle after the write edge. Visible through bypass: the same cycle.
- busy vector: registered only, and reflects updates one cycle after the edge.
- Reset asserted mid-operation:
  - storage, busy and read registers go to 0 immediately, asynchronously;
  - writes presented during reset are ignored.
  - After deassertion, the first write takes effect on the first rising edge with reset low.
- Reset values: rd_data = 0 (registered mode), or reads of a cleared file = 0 (combinational mode); rd_busy = 0; busy = 0.

## Test plan
- Reset, then read all NREGS addresses -> every rd_data = 0 and busy = 0, including register NREGS-1.
- Write port 0: reg 5 = 0xDEAD_BEEF_0000_0001. Same cycle, read port 0 addr 5 with BYPASS=1 -> rd_data = the new value. With BYPASS=0 -> 0; the next cycle -> the new value.
- Ports 0 and 1 both write reg 7 (0x11, 0x22) -> reg 7 = 0x22, and the bypassed read returns 0x22.
- ZERO_REG=1: write reg 0 = 0xFF, then bs_en on reg 0 -> reads of reg 0 = 0; busy[0] = 0.
- bs_en reg 9 -> busy[9]=1 next cycle. Then write reg 9 with bs_en reg 9 in the same cycle -> busy[9] stays 1. Then write only -> busy[9]=0; the rd_busy of a port reading 9 shows 0 in the write cycle when BYPASS=1.
- RD_REG=1: write reg 3 = 0x42 while reading reg 3; assert reset in the following cycle -> rd_data is 0x42 one cycle later. Reset drives rd_data, reg 3 and busy to 0 without waiting for a clock edge.
